custom_acc_multi: RTL and testbench



---
 rtl/custom_acc_multi.sv | 141 ++++++++++++++
 tb/tb_custom_acc_multi.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_acc_multi.sv
// -----------------------------------------------------------------------------
// custom_acc_multi
//
// Multi-channel latency emulator. Each of NUM_CH independent channels accepts a
// start request with a per-request cycle count, stays busy for exactly that
// many cycles, then holds a finish flag until the host acknowledges it.
//
// Optional feature macro: ACC_ABORT_EN
//   defined     -> per-channel abort returns RUN/DONE to IDLE with no finish
//   not defined -> i_abort is accepted but ignored; runs always complete
//
// Parameters:
//   NUM_CH         number of independent channels (1..16)
//   CNT_W          width of each channel's count / down-counter (8..64)
//   DEFAULT_CYCLES run length used when a requested count is 0 (>=1)
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   asynchronous, active-low; forces every channel to IDLE
//   i_start     in   [NUM_CH]        per-channel start request (level)
//   i_cycles    in   [NUM_CH*CNT_W]  per-channel run length, slice k*CNT_W
//   i_ack       in   [NUM_CH]        per-channel acknowledge of finish
//   i_abort     in   [NUM_CH]        per-channel abort (ACC_ABORT_EN only)
//   o_busy      out  [NUM_CH]        channel in RUN
//   o_finish    out  [NUM_CH]        channel in DONE (held until ack)
//   o_all_idle  out                  every channel in IDLE
// -----------------------------------------------------------------------------
module custom_acc_multi #(
    parameter int                NUM_CH         = 4,
    parameter int                CNT_W          = 32,
    parameter longint unsigned   DEFAULT_CYCLES = 64'd50000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         i_start,
    input  logic [NUM_CH*CNT_W-1:0]   i_cycles,
    input  logic [NUM_CH-1:0]         i_ack,
    input  logic [NUM_CH-1:0]         i_abort,
    output logic [NUM_CH-1:0]         o_busy,
    output logic [NUM_CH-1:0]         o_finish,
    output logic                      o_all_idle
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEF_CNT = CNT_W'(DEFAULT_CYCLES);

    logic [NUM_CH-1:0] idle_vec;

`ifndef ACC_ABORT_EN
    // Abort port is kept for a stable interface but feeds nothing.
    logic unused_abort;
    assign unused_abort = ^i_abort;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_t           state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic [CNT_W-1:0] req, reload;
        logic             abort;

`ifdef ACC_ABORT_EN
        assign abort = i_abort[k];
`else
        assign abort = 1'b0;
`endif

        // A zero request selects the default run length. The counter is
        // loaded with N-1 so that the RUN->DONE edge lands exactly N edges
        // after the start edge.
        assign req    = i_cycles[k*CNT_W +: CNT_W];
        assign reload = ((req == '0) ? DEF_CNT : req) - CNT_W'(1);

        // NOTE: state registers use non-blocking assignments so every channel
        // samples the pre-edge values of all signals.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            unique case (state)
                ST_IDLE: begin
                    cnt_nxt = '0;
                    // Abort in IDLE suppresses a same-cycle start.
                    if (i_start[k] && !abort) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = reload;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (i_ack[k] && i_start[k]) begin
                        // Start held through ack chains runs with no idle gap.
                        state_nxt = ST_RUN;
                        cnt_nxt   = reload;
                    end else if (i_ack[k]) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign o_busy[k]   = (state == ST_RUN);
        assign o_finish[k] = (state == ST_DONE);
        assign idle_vec[k] = (state == ST_IDLE);
    end

    assign o_all_idle = &idle_vec;

endmodule

// File: tb/tb_custom_acc_multi.sv
// -----------------------------------------------------------------------------
// tb_custom_acc_multi
//
// Self-checking bench for custom_acc_multi (NUM_CH=4, CNT_W=32,
// DEFAULT_CYCLES=20). Directed scenario tasks check the timing rules with
// explicit expected values; a randomized task compares every cycle against a
// reference model that tracks each channel as a phase plus the absolute cycle
// at which its run ends. Abort expectations follow ACC_ABORT_EN.
// -----------------------------------------------------------------------------
module tb_custom_acc_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int DEF    = 20;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       i_start;
    logic [NUM_CH*CNT_W-1:0] i_cycles;
    logic [NUM_CH-1:0]       i_ack;
    logic [NUM_CH-1:0]       i_abort;
    logic [NUM_CH-1:0]       o_busy;
    logic [NUM_CH-1:0]       o_finish;
    logic                    o_all_idle;

    int     checks   = 0;
    int     failures = 0;
    longint t        = 0;
    int     m_phase [NUM_CH];
    longint m_end   [NUM_CH];

    custom_acc_multi #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .DEFAULT_CYCLES (64'(DEF))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_cycles   (i_cycles),
        .i_ack      (i_ack),
        .i_abort    (i_abort),
        .o_busy     (o_busy),
        .o_finish   (o_finish),
        .o_all_idle (o_all_idle)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint run_len(input int ch);
        logic [CNT_W-1:0] s;
        s = i_cycles[ch*CNT_W +: CNT_W];
        return (s == '0) ? longint'(DEF) : longint'(s);
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_phase[ch] = P_IDLE;
            m_end[ch]   = 0;
        end
    endtask

    // Called once per rising edge with the inputs that edge sampled.
    task automatic model_edge();
        bit ab;
        t++;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ab = 1'b0;
`ifdef ACC_ABORT_EN
            ab = i_abort[ch];
`endif
            case (m_phase[ch])
                P_IDLE: if (!ab && i_start[ch]) begin
                    m_phase[ch] = P_RUN;
                    m_end[ch]   = t + run_len(ch);
                end
                P_RUN: begin
                    if (ab)                 m_phase[ch] = P_IDLE;
                    else if (t == m_end[ch]) m_phase[ch] = P_DONE;
                end
                default: begin
                    if (ab) m_phase[ch] = P_IDLE;
                    else if (i_ack[ch] && i_start[ch]) begin
                        m_phase[ch] = P_RUN;
                        m_end[ch]   = t + run_len(ch);
                    end else if (i_ack[ch]) m_phase[ch] = P_IDLE;
                end
            endcase
        end
    endtask

    function automatic logic [NUM_CH-1:0] exp_busy();
        logic [NUM_CH-1:0] e;
        for (int ch = 0; ch < NUM_CH; ch++) e[ch] = (m_phase[ch] == P_RUN);
        return e;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_finish();
        logic [NUM_CH-1:0] e;
        for (int ch = 0; ch < NUM_CH; ch++) e[ch] = (m_phase[ch] == P_DONE);
        return e;
    endfunction

    function automatic logic exp_idle();
        logic e = 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++) if (m_phase[ch] != P_IDLE) e = 1'b0;
        return e;
    endfunction

    // One clock edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_cycles(input int ch, input logic [CNT_W-1:0] v);
        i_cycles[ch*CNT_W +: CNT_W] = v;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; i_start = '0; i_ack = '0; i_abort = '0; i_cycles = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        if ({o_busy, o_finish, o_all_idle} !== {4'b0, 4'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_during got=%b_%b_%b exp=0000_0000_1", o_busy, o_finish, o_all_idle);
        end
        checks++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        if ({o_busy, o_finish, o_all_idle} !== {4'b0, 4'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_after got=%b_%b_%b exp=0000_0000_1", o_busy, o_finish, o_all_idle);
        end
        checks++;
    endtask

    task automatic test_single();
        int n = 0;
        set_cycles(0, 5);
        i_start[0] = 1'b1;
        step();
        i_start[0] = 1'b0;
        while (o_busy[0] && n < 100) begin n++; step(); end
        if (n != 5) begin
            failures++; $display("FAIL single_busy_len got=%0d exp=5", n);
        end
        checks++;
        repeat (3) step();
        if (o_finish[0] !== 1'b1 || o_busy[0] !== 1'b0) begin
            failures++; $display("FAIL single_finish_hold got=%b exp=1", o_finish[0]);
        end
        checks++;
        i_ack[0] = 1'b1;
        step();
        i_ack[0] = 1'b0;
        if (o_finish[0] !== 1'b0 || o_all_idle !== 1'b1) begin
            failures++;
            $display("FAIL single_ack got=%b/%b exp=0/1", o_finish[0], o_all_idle);
        end
        checks++;
    endtask

    task automatic test_lengths();
        int req [2] = '{1, 0};
        int want[2] = '{1, DEF};
        for (int c = 0; c < 2; c++) begin
            int n = 0;
            set_cycles(0, CNT_W'(req[c]));
            i_start[0] = 1'b1;
            step();
            i_start[0] = 1'b0;
            while (o_busy[0] && n < 100) begin n++; step(); end
            if (n != want[c] || o_finish[0] !== 1'b1) begin
                failures++;
                $display("FAIL len_req%0d got=%0d fin=%b exp=%0d", req[c], n, o_finish[0], want[c]);
            end
            checks++;
            i_ack[0] = 1'b1; step(); i_ack[0] = 1'b0;
        end
    endtask

    task automatic test_multi();
        int cnt [NUM_CH] = '{3, 7, 2, 10};
        int rise[NUM_CH] = '{-1, -1, -1, -1};
        for (int ch = 0; ch < NUM_CH; ch++) set_cycles(ch, CNT_W'(cnt[ch]));
        i_start = '1;
        step();
        i_start = '0;
        for (int k = 1; k <= 12; k++) begin
            step();
            for (int ch = 0; ch < NUM_CH; ch++)
                if (rise[ch] < 0 && o_finish[ch]) rise[ch] = k;
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rise[ch] != cnt[ch]) begin
                failures++; $display("FAIL multi_rise_ch%0d got=%0d exp=%0d", ch, rise[ch], cnt[ch]);
            end
            checks++;
        end
        i_ack = 4'b0111;
        step();
        i_ack = '0;
        if (o_all_idle !== 1'b0 || o_finish !== 4'b1000) begin
            failures++; $display("FAIL multi_partial_ack got=%b/%b exp=0/1000", o_all_idle, o_finish);
        end
        checks++;
        i_ack = 4'b1000;
        step();
        i_ack = '0;
        if (o_all_idle !== 1'b1) begin
            failures++; $display("FAIL multi_all_idle got=%b exp=1", o_all_idle);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        set_cycles(1, 4);
        i_start[1] = 1'b1;
        step();
        while (!o_finish[1] && n < 50) begin n++; step(); end
        if (n != 4) begin
            failures++; $display("FAIL b2b_first_len got=%0d exp=4", n);
        end
        checks++;
        i_ack[1] = 1'b1;
        step();
        i_ack[1] = 1'b0;
        if (o_busy[1] !== 1'b1 || o_finish[1] !== 1'b0) begin
            failures++; $display("FAIL b2b_no_gap busy=%b fin=%b exp=1/0", o_busy[1], o_finish[1]);
        end
        checks++;
        n = 0;
        while (o_busy[1] && n < 50) begin n++; step(); end
        if (n != 4) begin
            failures++; $display("FAIL b2b_second_len got=%0d exp=4", n);
        end
        checks++;
        i_start[1] = 1'b0;
        i_ack[1]   = 1'b1; step(); i_ack[1] = 1'b0;
        // Fresh run with a start pulse in its middle: length stays 4.
        i_start[1] = 1'b1;
        step();
        n = 0;
        while (o_busy[1] && n < 50) begin
            i_start[1] = (n == 2);
            n++;
            step();
        end
        i_start[1] = 1'b0;
        if (n != 4 || o_finish[1] !== 1'b1) begin
            failures++; $display("FAIL b2b_midrun_start got=%0d fin=%b exp=4/1", n, o_finish[1]);
        end
        checks++;
        i_ack[1] = 1'b1; step(); i_ack[1] = 1'b0;
    endtask

    task automatic test_abort();
        int n = 0;
        set_cycles(2, 10);
        i_start[2] = 1'b1;
        step();
        i_start[2] = 1'b0;
        step(); step();
        i_abort[2] = 1'b1;
        step();
        i_abort[2] = 1'b0;
`ifdef ACC_ABORT_EN
        if (o_busy[2] !== 1'b0 || o_finish[2] !== 1'b0) begin
            failures++; $display("FAIL abort_run busy=%b fin=%b exp=0/0", o_busy[2], o_finish[2]);
        end
        checks++;
        for (int k = 0; k < 15; k++) begin
            step();
            if (o_finish[2]) n++;
        end
        if (n != 0) begin
            failures++; $display("FAIL abort_no_finish got=%0d exp=0", n);
        end
        checks++;
`else
        n = 3;
        while (o_busy[2] && n < 50) begin n++; step(); end
        if (n != 10 || o_finish[2] !== 1'b1) begin
            failures++; $display("FAIL abort_ignored_len got=%0d fin=%b exp=10/1", n, o_finish[2]);
        end
        checks++;
        i_ack[2] = 1'b1; step(); i_ack[2] = 1'b0;
`endif
        // Abort + ack + start together while DONE.
        set_cycles(2, 3);
        i_start[2] = 1'b1; step(); i_start[2] = 1'b0;
        n = 0;
        while (!o_finish[2] && n < 50) begin n++; step(); end
        i_abort[2] = 1'b1; i_ack[2] = 1'b1; i_start[2] = 1'b1;
        step();
        i_abort[2] = 1'b0; i_ack[2] = 1'b0; i_start[2] = 1'b0;
`ifdef ACC_ABORT_EN
        if (o_busy[2] !== 1'b0 || o_finish[2] !== 1'b0 || o_all_idle !== 1'b1) begin
            failures++; $display("FAIL abort_done busy=%b fin=%b idle=%b exp=0/0/1", o_busy[2], o_finish[2], o_all_idle);
        end
        checks++;
`else
        if (o_busy[2] !== 1'b1 || o_finish[2] !== 1'b0) begin
            failures++; $display("FAIL abort_done_restart busy=%b fin=%b exp=1/0", o_busy[2], o_finish[2]);
        end
        checks++;
`endif
        // Drain to idle (ack is ignored while running).
        i_ack = '1;
        n = 0;
        while (!o_all_idle && n < 100) begin n++; step(); end
        i_ack = '0;
        if (o_all_idle !== 1'b1) begin
            failures++; $display("FAIL abort_drain got=%b exp=1", o_all_idle);
        end
        checks++;
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        set_cycles(3, 100);
        i_start[3] = 1'b1; step(); i_start[3] = 1'b0;
        repeat (39) step();
        if (o_busy[3] !== 1'b1) begin
            failures++; $display("FAIL rstmid_busy_before got=%b exp=1", o_busy[3]);
        end
        checks++;
        #2 reset = 1'b0;
        #1;
        model_reset();
        if (o_busy !== 4'b0 || o_finish !== 4'b0 || o_all_idle !== 1'b1) begin
            failures++; $display("FAIL rstmid_async got=%b_%b_%b exp=0000_0000_1", o_busy, o_finish, o_all_idle);
        end
        checks++;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 110; k++) begin
            step();
            if (o_finish[3] || o_busy[3]) n++;
        end
        if (n != 0) begin
            failures++; $display("FAIL rstmid_no_finish active_cycles=%0d exp=0", n);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            i_start = NUM_CH'($urandom);
            i_ack   = NUM_CH'($urandom);
            i_abort = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
            for (int ch = 0; ch < NUM_CH; ch++) set_cycles(ch, CNT_W'($urandom_range(0, 6)));
            step();
            if (o_busy !== exp_busy()) begin
                failures++; $display("FAIL rand_busy t=%0d got=%b exp=%b", t, o_busy, exp_busy());
            end
            checks++;
            if (o_finish !== exp_finish()) begin
                failures++; $display("FAIL rand_finish t=%0d got=%b exp=%b", t, o_finish, exp_finish());
            end
            checks++;
            if (o_all_idle !== exp_idle()) begin
                failures++; $display("FAIL rand_all_idle t=%0d got=%b exp=%b", t, o_all_idle, exp_idle());
            end
            checks++;
        end
        i_start = '0; i_ack = '0; i_abort = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_lengths();
        test_multi();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
